// File: rtl/seq_addsub_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_addsub_if : operand/result handshake bundle for seq_addsub        |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
interface seq_addsub_if #(
   parameter int N = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [N:0]   Sum;
   logic         ovf;

   modport master (
      output in_valid, A, B, sub, out_ready,
      input  in_ready, out_valid, Sum, ovf
   );

   modport slave (
      input  in_valid, A, B, sub, out_ready,
      output in_ready, out_valid, Sum, ovf
   );
endinterface
`default_nettype wire

// File: rtl/seq_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_addsub : chunk-serial signed add/subtract, M bits per cycle       |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module seq_addsub #(
   parameter int N   = 16,
   parameter int M   = 4,
   parameter int SAT = 0
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   seq_addsub_if.slave bus
);
   localparam int CHUNKS = N / M;
   localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [KW-1:0] LAST_K = KW'(CHUNKS - 1);

   generate
      if (N < 2 || M < 1 || (N % M) != 0) begin : g_bad_params
         $error("seq_addsub: need N >= 2, M >= 1 and M dividing N");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] bp_q, bp_d;
   logic [N-1:0] acc_q, acc_d;
   logic [KW-1:0] k_q, k_d;
   logic         carry_q, carry_d;
   logic [N:0]   sum_q, sum_d;
   logic         ovf_q, ovf_d;

   int           base;
   logic [M-1:0] a_chunk;
   logic [M-1:0] b_chunk;
   logic [M:0]   chunk_sum;
   logic [N-1:0] acc_upd;
   logic [N:0]   sum_exact;
   logic         ovf_exact;
   logic [N:0]   sat_limit;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      bp_d    = bp_q;
      acc_d   = acc_q;
      k_d     = k_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;

      base      = int'(k_q) * M;
      a_chunk   = a_q[base +: M];
      b_chunk   = bp_q[base +: M];
      chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{M{1'b0}}, carry_q};
      acc_upd   = acc_q;
      acc_upd[base +: M] = chunk_sum[M-1:0];

      // Sign-extending both operands makes bit N the XOR of their MSBs and the carry out.
      sum_exact = {a_q[N-1] ^ bp_q[N-1] ^ chunk_sum[M], acc_upd};
      ovf_exact = sum_exact[N] ^ sum_exact[N-1];
      sat_limit = sum_exact[N] ? {2'b11, {(N-1){1'b0}}} : {2'b00, {(N-1){1'b1}}};

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.A;
               bp_d    = bus.sub ? ~bus.B : bus.B;
               acc_d   = '0;
               k_d     = '0;
               carry_d = bus.sub;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d   = acc_upd;
            carry_d = chunk_sum[M];
            k_d     = k_q + KW'(1);
            if (k_q == LAST_K) begin
               k_d     = '0;
               ovf_d   = ovf_exact;
               sum_d   = (SAT != 0 && ovf_exact) ? sat_limit : sum_exact;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         bp_q    <= '0;
         acc_q   <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         bp_q    <= bp_d;
         acc_q   <= acc_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.Sum       = sum_q;
   assign bus.ovf       = ovf_q;
endmodule
`default_nettype wire
